// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state encoding and
// requester-select codes.
package mem_arb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } sel_t;

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating 4-bit count of data grants issued while fetch is waiting.
module mem_arb_starve #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 4'(MAX))) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_max = (r_cnt == 4'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data; data has priority, bounded by
// a starvation counter. One transaction in flight; the state names its owner.
//   state  | meaning
//   IDLE   | no transaction outstanding
//   BUSY_I | fetch read outstanding
//   BUSY_D | data load/store outstanding
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W     = XLEN,
  parameter int          DATA_W     = XLEN,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  state_t r_state, w_state_nxt;
  sel_t   w_sel;
  logic   r_discard, r_err;
  logic   w_resp, w_issue, w_accept, w_at_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A response frees the port in the same cycle, allowing back-to-back issue.
  always_comb begin
    w_resp      = (r_state != IDLE) && m_rvalid;
    w_issue     = reset_n && ((r_state == IDLE) || w_resp);
    w_sel       = SEL_NONE;
    if (w_issue) begin
      if (d_req && !(i_req && w_at_max)) begin
        w_sel = SEL_D;
      end else if (i_req) begin
        w_sel = SEL_I;
      end
    end
    w_accept    = (w_sel != SEL_NONE) && m_ack;
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = (w_sel == SEL_D) ? BUSY_D : BUSY_I;
    end else if (w_resp) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    m_req   = 1'b0;
    m_addr  = '0;
    m_we    = '0;
    m_wdata = '0;
    case (w_sel)
      SEL_D: begin
        m_req   = 1'b1;
        m_addr  = d_addr;
        m_we    = d_we;
        m_wdata = d_wdata;
      end
      SEL_I: begin
        m_req   = 1'b1;
        m_addr  = i_addr;
      end
      default: ;
    endcase
    i_gnt    = w_accept && (w_sel == SEL_I);
    d_gnt    = w_accept && (w_sel == SEL_D);
    d_rvalid = reset_n && (r_state == BUSY_D) && m_rvalid;
    i_rvalid = reset_n && (r_state == BUSY_I) && m_rvalid && !r_discard && !i_kill;
    i_rdata  = reset_n ? m_rdata : '0;
    d_rdata  = reset_n ? m_rdata : '0;
    err      = r_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_discard <= 1'b0;
    end else if (r_state == BUSY_I) begin
      if (m_rvalid) begin
        r_discard <= 1'b0;
      end else if (i_kill) begin
        r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if ((m_rvalid && (r_state == IDLE)) || (m_ack && !m_req)) begin
      r_err <= 1'b1;
    end
  end

  mem_arb_starve #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_inc    (d_gnt && i_req),
    .i_clr    (i_gnt || !i_req),
    .o_at_max (w_at_max)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a cycle-level reference
// model of owner, starvation count, discard and error state.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int OWN_NONE = 0, OWN_I = 1, OWN_D = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, i_kill, d_req, m_ack, m_rvalid;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_we;
  logic [DW-1:0] d_wdata, m_rdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, err;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_we;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int md_owner = OWN_NONE;
  int md_starve = 0;
  bit md_disc = 0;
  bit md_err = 0;

  // expected outputs for the current cycle
  int            e_sel;
  logic          e_mreq, e_ignt, e_dgnt, e_irv, e_drv, e_err;
  logic [AW-1:0] e_maddr;
  logic [3:0]    e_mwe;
  logic [DW-1:0] e_mwdata, e_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    e_sel = OWN_NONE;
    if (reset_n && ((md_owner == OWN_NONE) || m_rvalid)) begin
      if (d_req && !(i_req && md_starve == SM)) e_sel = OWN_D;
      else if (i_req)                           e_sel = OWN_I;
    end
    e_mreq   = (e_sel != OWN_NONE);
    e_maddr  = (e_sel == OWN_D) ? d_addr : (e_sel == OWN_I) ? i_addr : '0;
    e_mwe    = (e_sel == OWN_D) ? d_we : 4'h0;
    e_mwdata = (e_sel == OWN_D) ? d_wdata : '0;
    e_dgnt   = (e_sel == OWN_D) && m_ack;
    e_ignt   = (e_sel == OWN_I) && m_ack;
    e_drv    = reset_n && (md_owner == OWN_D) && m_rvalid;
    e_irv    = reset_n && (md_owner == OWN_I) && m_rvalid && !md_disc && !i_kill;
    e_rdata  = reset_n ? m_rdata : '0;
    e_err    = reset_n ? md_err : 1'b0;
  endtask

  task automatic model_reset();
    md_owner = OWN_NONE; md_starve = 0; md_disc = 0; md_err = 0;
  endtask

  task automatic advance();
    if (!reset_n) begin
      model_reset();
      return;
    end
    if ((m_rvalid && md_owner == OWN_NONE) || (m_ack && !e_mreq)) md_err = 1;
    if (md_owner == OWN_I) begin
      if (m_rvalid)    md_disc = 0;
      else if (i_kill) md_disc = 1;
    end
    if (!i_req || e_ignt)                md_starve = 0;
    else if (e_dgnt && md_starve < SM)   md_starve = md_starve + 1;
    if (e_dgnt)        md_owner = OWN_D;
    else if (e_ignt)   md_owner = OWN_I;
    else if (m_rvalid) md_owner = OWN_NONE;
  endtask

  task automatic settle();
    #1;
    predict();
    chk("m_req",    {63'd0, m_req},    {63'd0, e_mreq});
    chk("m_addr",   {32'd0, m_addr},   {32'd0, e_maddr});
    chk("m_we",     {60'd0, m_we},     {60'd0, e_mwe});
    chk("m_wdata",  {32'd0, m_wdata},  {32'd0, e_mwdata});
    chk("i_gnt",    {63'd0, i_gnt},    {63'd0, e_ignt});
    chk("d_gnt",    {63'd0, d_gnt},    {63'd0, e_dgnt});
    chk("i_rvalid", {63'd0, i_rvalid}, {63'd0, e_irv});
    chk("d_rvalid", {63'd0, d_rvalid}, {63'd0, e_drv});
    chk("i_rdata",  {32'd0, i_rdata},  {32'd0, e_rdata});
    chk("d_rdata",  {32'd0, d_rdata},  {32'd0, e_rdata});
    chk("err",      {63'd0, err},      {63'd0, e_err});
  endtask

  task automatic clock();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 0; i_kill = 0; d_req = 0; d_we = 0; d_wdata = 0;
    m_ack = 0; m_rvalid = 0; m_rdata = 0; i_addr = 0; d_addr = 0;
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    @(negedge clk);
    // reset with requests pending: outputs must be quiet
    i_req = 1; d_req = 1; d_addr = 32'h55; m_ack = 1; m_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rst_mreq", {63'd0, m_req}, 64'd0);
    chk("rst_rdata", {32'd0, i_rdata}, 64'd0);
    clock();
    idle_inputs();
    reset_n = 1;
    settle(); clock();

    // lone fetch, 1-cycle memory
    i_req = 1; i_addr = 32'h4000_0000; m_ack = 1;
    settle();
    chk("lone_ignt", {63'd0, i_gnt}, 64'd1);
    chk("lone_maddr", {32'd0, m_addr}, 64'h4000_0000);
    clock();
    i_req = 0; m_ack = 0; m_rvalid = 1; m_rdata = 32'h0000_0013;
    settle();
    chk("lone_irv", {63'd0, i_rvalid}, 64'd1);
    chk("lone_irdata", {32'd0, i_rdata}, 64'h13);
    clock();
    m_rvalid = 0;

    // contention: data first, fetch back-to-back on the response
    i_req = 1; i_addr = 32'h4000_0004;
    d_req = 1; d_addr = 32'h1000_0000; d_we = 4'hF; d_wdata = 32'hA5A5_5A5A; m_ack = 1;
    settle();
    chk("cont_dgnt", {63'd0, d_gnt}, 64'd1);
    chk("cont_ignt0", {63'd0, i_gnt}, 64'd0);
    chk("cont_mwe", {60'd0, m_we}, 64'hF);
    clock();
    d_req = 0; d_we = 0; m_rvalid = 1; m_rdata = 32'h1;
    settle();
    chk("cont_drv", {63'd0, d_rvalid}, 64'd1);
    chk("cont_ignt1", {63'd0, i_gnt}, 64'd1);
    clock();
    i_req = 0; m_ack = 0; m_rdata = 32'h2;
    settle();
    chk("cont_irv", {63'd0, i_rvalid}, 64'd1);
    clock();
    m_rvalid = 0;

    // starvation: 4 data grants, 1 fetch, data resumes
    i_req = 1; i_addr = 32'h4000_0100; d_req = 1; d_addr = 32'h2000_0000; m_ack = 1;
    for (int k = 0; k < 9; k++) begin
      m_rvalid = (k != 0);
      m_rdata = $urandom;
      settle();
      chk("starve_dgnt", {63'd0, d_gnt}, (k == 4) ? 64'd0 : 64'd1);
      chk("starve_ignt", {63'd0, i_gnt}, (k == 4) ? 64'd1 : 64'd0);
      clock();
    end
    idle_inputs();
    m_rvalid = 1;
    settle(); clock();
    m_rvalid = 0;

    // kill the cycle before the response
    i_req = 1; i_addr = 32'h4000_0200; m_ack = 1;
    settle(); clock();
    i_req = 0; m_ack = 0; i_kill = 1;
    settle(); clock();
    i_kill = 0; m_rvalid = 1; m_rdata = 32'h77;
    settle();
    chk("kill_irv", {63'd0, i_rvalid}, 64'd0);
    clock();
    m_rvalid = 0; d_req = 1; d_addr = 32'h3000_0000; m_ack = 1;
    settle();
    chk("kill_idle", {63'd0, d_gnt}, 64'd1);
    chk("kill_err", {63'd0, err}, 64'd0);
    clock();
    d_req = 0; m_ack = 0; m_rvalid = 1;
    settle(); clock();
    // kill coinciding with the response
    m_rvalid = 0; i_req = 1; m_ack = 1;
    settle(); clock();
    i_req = 0; m_ack = 0; m_rvalid = 1; i_kill = 1;
    settle();
    chk("kill_same_irv", {63'd0, i_rvalid}, 64'd0);
    clock();
    idle_inputs();

    // reset in BUSY_D with data request pending
    d_req = 1; d_addr = 32'h1234_5678; m_ack = 1;
    settle(); clock();
    d_addr = 32'h1234_567C; reset_n = 0; m_rvalid = 1;
    settle();
    chk("rstmid_mreq", {63'd0, m_req}, 64'd0);
    chk("rstmid_dgnt", {63'd0, d_gnt}, 64'd0);
    chk("rstmid_drv", {63'd0, d_rvalid}, 64'd0);
    clock();
    reset_n = 1; m_rvalid = 0;
    settle();
    chk("rstmid_after", {63'd0, d_gnt}, 64'd1);
    clock();
    d_req = 0; m_ack = 0; m_rvalid = 1;
    settle();
    chk("rstmid_drv2", {63'd0, d_rvalid}, 64'd1);
    clock();
    idle_inputs();

    // protocol error: response with nothing outstanding
    m_rvalid = 1;
    settle();
    chk("err_pre", {63'd0, err}, 64'd0);
    chk("err_drv", {63'd0, d_rvalid}, 64'd0);
    clock();
    m_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("err_sticky", {63'd0, err}, 64'd1);
      clock();
    end
    reset_n = 0;
    settle(); clock();
    reset_n = 1;
    // ack without request
    m_ack = 1;
    settle(); clock();
    m_ack = 0;
    settle();
    chk("err_ack", {63'd0, err}, 64'd1);
    clock();
    reset_n = 0;
    settle(); clock();
    reset_n = 1;
    idle_inputs();
    settle(); clock();

    // random traffic; requests held until granted, memory legal
    for (int k = 0; k < 800; k++) begin
      if (!i_req || e_ignt) begin
        i_req = ($urandom_range(0, 1) == 1);
        i_addr = $urandom;
      end
      if (!d_req || e_dgnt) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_addr = $urandom;
        d_we = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      i_kill = ($urandom_range(0, 5) == 0);
      m_rvalid = (md_owner != OWN_NONE) && ($urandom_range(0, 2) != 0);
      m_rdata = $urandom;
      m_ack = 0;
      predict();
      m_ack = e_mreq && ($urandom_range(0, 3) != 0);
      settle();
      clock();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
